fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the 16-bit word-addressed instruction memory (combinational read, 256 words used). It owns the program counter and presents one fetched instruction per cycle to the IF/ID boundary. It also handles stall, control-flow redirect (branch/JMP/CALL/RET), halt/resume, and an optional return-address stack for CALL/RET. It sits between the hazard/branch logic in decode/execute and the instruction memory.

---
 rtl/fetch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, registers one fetched word per cycle into IF/ID,
// handles stall/redirect/halt. Optional return-address stack built when FETCH_RAS_EN is defined.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        halt,
    input  logic        resume,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted,
    input  logic        ras_push,
    input  logic [15:0] ras_push_addr,
    input  logic        ras_pop,
    output logic [15:0] ras_top,
    output logic        ras_empty,
    output logic        ras_underflow
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] instr_nxt, if_pc_nxt, if_pc_plus1_nxt;
    logic        valid_nxt;
    logic [15:0] pc_inc;

    assign pc_inc    = pc + 16'd1;
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_instr    <= NOP_INSTR;
            if_pc       <= 16'h0000;
            if_pc_plus1 <= 16'h0000;
            if_valid    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            if_instr    <= instr_nxt;
            if_pc       <= if_pc_nxt;
            if_pc_plus1 <= if_pc_plus1_nxt;
            if_valid    <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = if_instr;
        if_pc_nxt       = if_pc;
        if_pc_plus1_nxt = if_pc_plus1;
        valid_nxt       = if_valid;
        case (state)
            BOOT: begin
                // First edge out of reset fetches the word at RESET_PC unconditionally.
                state_nxt       = RUN;
                instr_nxt       = imem_data;
                if_pc_nxt       = pc;
                if_pc_plus1_nxt = pc_inc;
                valid_nxt       = 1'b1;
                pc_nxt          = pc_inc;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Wrong-path word in flight is dropped: one bubble, target fetched next edge.
                    pc_nxt    = redirect_target;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (stall) begin
                    pc_nxt = pc;
                end else if (halt) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    state_nxt = HALT;
                end else begin
                    instr_nxt       = imem_data;
                    if_pc_nxt       = pc;
                    if_pc_plus1_nxt = pc_inc;
                    valid_nxt       = 1'b1;
                    pc_nxt          = pc_inc;
                end
            end
            HALT: begin
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
                if (redirect_valid) pc_nxt = redirect_target;
                // Resume only re-enters RUN; the held PC is fetched on the following edge.
                if (resume) state_nxt = RUN;
            end
            default: begin
                state_nxt = BOOT;
                pc_nxt    = RESET_PC;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end
        endcase
    end

`ifdef FETCH_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] RAS_FULL = (PW + 1)'(RAS_DEPTH);

    logic [15:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_ptr;
    logic [PW:0]   ras_cnt;
    logic          ras_uf;
    logic [PW-1:0] wr_idx;
    logic          wr_en;

    // Push+pop rewrites the current top in place; a lone push advances first.
    assign wr_idx = (ras_push && ras_pop) ? ras_ptr : ras_ptr + PW'(1);
    assign wr_en  = ras_push;

    always_ff @(posedge clk) begin
        if (wr_en) ras_mem[wr_idx] <= ras_push_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            ras_uf  <= 1'b0;
        end else begin
            case ({ras_push, ras_pop})
                2'b10: begin
                    // Circular storage: when full the new entry lands on the oldest slot.
                    ras_ptr <= ras_ptr + PW'(1);
                    if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (PW + 1)'(1);
                end
                2'b01: begin
                    if (ras_cnt == '0) begin
                        ras_uf <= 1'b1;
                    end else begin
                        ras_ptr <= ras_ptr - PW'(1);
                        ras_cnt <= ras_cnt - (PW + 1)'(1);
                    end
                end
                default: ras_cnt <= ras_cnt;
            endcase
        end
    end

    assign ras_empty     = (ras_cnt == '0);
    assign ras_top       = ras_empty ? 16'h0000 : ras_mem[ras_ptr];
    assign ras_underflow = ras_uf;
`else
    logic unused_ras;
    assign unused_ras    = ^{ras_push, ras_pop, ras_push_addr} ^ (RAS_DEPTH == 0);
    assign ras_top       = 16'h0000;
    assign ras_empty     = 1'b1;
    assign ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected IF/ID words, a negedge monitor
// pops and compares each newly presented valid word; control/RAS outputs are checked directly.
module tb_fetch_sequencer;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pc1;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0, resume = 1'b0;
    logic [15:0] redirect_target = 16'h0;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] if_instr, if_pc, if_pc_plus1;
    logic        if_valid, halted;
    logic        ras_push = 1'b0, ras_pop = 1'b0;
    logic [15:0] ras_push_addr = 16'h0;
    logic [15:0] ras_top;
    logic        ras_empty, ras_underflow;

    logic [15:0] mem [256];
    fetch_t      sb [$];
    int          compared = 0;
    int          mismatched = 0;
    logic        held = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .reset_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt), .resume(resume),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
        .if_valid(if_valid), .halted(halted),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [15:0] pc, input logic [15:0] pc1);
        fetch_t e;
        e.pc    = pc;
        e.instr = 16'hA000 | {8'h00, pc[7:0]};
        e.pc1   = pc1;
        sb.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        chk({tag, "_if_instr"}, 32'(if_instr), 32'h0000);
        chk({tag, "_if_pc"}, 32'(if_pc), 32'h0000);
        chk({tag, "_if_pc_plus1"}, 32'(if_pc_plus1), 32'h0000);
        chk({tag, "_imem_addr"}, 32'(imem_addr), 32'h0000);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_ras_empty"}, 32'(ras_empty), 32'd1);
        chk({tag, "_ras_top"}, 32'(ras_top), 32'h0000);
        chk({tag, "_ras_underflow"}, 32'(ras_underflow), 32'd0);
    endtask

    // A stalled edge re-presents the same word; only words from non-stall edges are new.
    always @(posedge clk) held <= stall;

    always @(negedge clk) begin
        if (rst_n && if_valid && !held) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_fetch: got if_pc %h with no expected entry", if_pc);
            end else begin
                fetch_t e;
                e = sb.pop_front();
                chk("mon_if_pc", 32'(if_pc), 32'(e.pc));
                chk("mon_if_instr", 32'(if_instr), 32'(e.instr));
                chk("mon_if_pc_plus1", 32'(if_pc_plus1), 32'(e.pc1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

        #1 rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst");
        step(2);
        rst_n = 1'b1;
        chk("boot_valid", 32'(if_valid), 32'd0);
        chk("boot_addr", 32'(imem_addr), 32'h0000);

        // Sequential fetch from reset, then a 3-cycle stall at if_pc=2.
        for (int p = 0; p < 5; p++) expect_fetch(16'(p), 16'(p + 1));
        step(3);
        chk("pre_stall_if_pc", 32'(if_pc), 32'h0002);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_if_pc", 32'(if_pc), 32'h0002);
            chk("stall_if_instr", 32'(if_instr), 32'hA002);
            chk("stall_imem_addr", 32'(imem_addr), 32'h0003);
        end
        stall = 1'b0;
        step(2);
        chk("post_stall_addr", 32'(imem_addr), 32'h0005);

        // Halt at PC=5, redirect to 9 while halted, then resume.
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(if_valid), 32'd0);
        chk("halt_addr", 32'(imem_addr), 32'h0005);
        step();
        chk("halt_hold_addr", 32'(imem_addr), 32'h0005);
        redirect_valid = 1'b1; redirect_target = 16'd9;
        step();
        redirect_valid = 1'b0;
        chk("halt_redir_halted", 32'(halted), 32'd1);
        chk("halt_redir_addr", 32'(imem_addr), 32'h0009);
        resume = 1'b1;
        step();
        resume = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_valid", 32'(if_valid), 32'd0);
        expect_fetch(16'd9, 16'd10);
        expect_fetch(16'd10, 16'd11);
        step(2);

        // Redirect to 17 overrides a simultaneous stall: exactly one bubble.
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'd17;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("redir_bubble_valid", 32'(if_valid), 32'd0);
        chk("redir_bubble_instr", 32'(if_instr), 32'h0000);
        chk("redir_addr", 32'(imem_addr), 32'h0011);
        expect_fetch(16'd17, 16'd18);
        expect_fetch(16'd18, 16'd19);
        step(2);

        // PC wrap at 16'hFFFF.
        redirect_valid = 1'b1; redirect_target = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        expect_fetch(16'hFFFF, 16'h0000);
        expect_fetch(16'h0000, 16'h0001);
        step(2);
        chk("wrap_addr", 32'(imem_addr), 32'h0001);

        // Stall outranks halt; then halt+resume in HALT keeps running.
        stall = 1'b1; halt = 1'b1;
        step();
        stall = 1'b0; halt = 1'b0;
        chk("stall_over_halt", 32'(halted), 32'd0);
        expect_fetch(16'd1, 16'd2);
        step();
        halt = 1'b1;
        step();
        chk("halt2_halted", 32'(halted), 32'd1);
        resume = 1'b1;
        step();
        halt = 1'b0; resume = 1'b0;
        chk("resume_wins", 32'(halted), 32'd0);
        expect_fetch(16'd2, 16'd3);
        step();

        // Return-address stack exercised while fetch is halted.
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("ras_phase_halted", 32'(halted), 32'd1);
        for (int v = 16'h10; v <= 16'h14; v++) begin
            ras_push = 1'b1; ras_push_addr = 16'(v);
            step();
        end
        ras_push = 1'b0;
`ifdef FETCH_RAS_EN
        begin
            logic [15:0] tops [4];
            tops = '{16'h0014, 16'h0013, 16'h0012, 16'h0011};
            chk("ras_full_empty", 32'(ras_empty), 32'd0);
            for (int k = 0; k < 4; k++) begin
                chk("ras_top_pop", 32'(ras_top), 32'(tops[k]));
                ras_pop = 1'b1;
                step();
                ras_pop = 1'b0;
            end
        end
        chk("ras_drained_empty", 32'(ras_empty), 32'd1);
        chk("ras_drained_top", 32'(ras_top), 32'h0000);
        chk("ras_no_uf_yet", 32'(ras_underflow), 32'd0);
        ras_pop = 1'b1;
        step();
        ras_pop = 1'b0;
        chk("ras_underflow", 32'(ras_underflow), 32'd1);
        chk("ras_uf_empty", 32'(ras_empty), 32'd1);
        ras_push = 1'b1; ras_push_addr = 16'h0020;
        step();
        ras_push_addr = 16'h0030; ras_pop = 1'b1;
        step();
        ras_push = 1'b0; ras_pop = 1'b0;
        chk("ras_pushpop_top", 32'(ras_top), 32'h0030);
        ras_pop = 1'b1;
        step();
        ras_pop = 1'b0;
        chk("ras_pushpop_count", 32'(ras_empty), 32'd1);
        chk("ras_uf_sticky", 32'(ras_underflow), 32'd1);
`else
        chk("noras_top", 32'(ras_top), 32'h0000);
        chk("noras_empty", 32'(ras_empty), 32'd1);
        ras_pop = 1'b1;
        step(6);
        ras_pop = 1'b0;
        chk("noras_underflow", 32'(ras_underflow), 32'd0);
`endif
        chk("ras_still_halted", 32'(halted), 32'd1);

        // Resume, fetch two words, then async reset mid-cycle.
        resume = 1'b1;
        step();
        resume = 1'b0;
        expect_fetch(16'd3, 16'd4);
        expect_fetch(16'd4, 16'd5);
        step(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
